// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizes for the multiply issue/retire stage
package mult_pkg;
  localparam int TAGW = 5;
  localparam int MUL_LAT = 18;
  localparam int DEPTH = 24;
  typedef enum logic [1:0] {MUL, MULH, MULHU, MULHSU} op_t;
  typedef struct packed {
    logic vld;
    op_t op;
    logic [TAGW-1:0] tag;
  } mtag_t;
  function automatic logic [127:0] sel_half(op_t op, logic [255:0] p);
    return op == MUL ? p[127:0] : p[255:128];
  endfunction
endpackage

// File: rtl/mult_issue_unit_if.sv
// mult_issue_unit_if: request/result handshake bundle
//   req_*: tagged multiply request (valid/ready), res_*: FWFT result head, busy: unit not idle
interface mult_issue_unit_if;
  import mult_pkg::*;
  logic req_valid;
  logic req_ready;
  op_t req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [TAGW-1:0] req_tag;
  logic res_valid;
  logic res_ready;
  logic [127:0] res_data;
  logic [TAGW-1:0] res_tag;
  logic busy;
  modport master(output req_valid, req_op, req_a, req_b, req_tag, res_ready,
                 input req_ready, res_valid, res_data, res_tag, busy);
  modport slave(input req_valid, req_op, req_a, req_b, req_tag, res_ready,
                output req_ready, res_valid, res_data, res_tag, busy);
endinterface

// File: rtl/mult128x128.sv
// mult128x128: pipelined 128x128 -> 256 multiplier, ss = s*s, su = s*u, else u*u
//   clk/ce: clock and enable of the product stages (input stage always loads)
//   a/b/ss/su: operands and mode, p: full 256-bit product MUL_LAT clocks after the input stage
module mult128x128 import mult_pkg::*; (
  input  logic         clk,
  input  logic         ce,
  input  logic         ss,
  input  logic         su,
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic [255:0] p
);
  logic [127:0] r_a, r_b;
  logic r_ss, r_su;
  logic [255:0] r_pipe [MUL_LAT];
  logic [255:0] w_ax, w_bx;
  // sign-extend to 256 bits; the truncated modular product is the exact signed result
  assign w_ax = {{128{(r_ss | r_su) & r_a[127]}}, r_a};
  assign w_bx = {{128{r_ss & r_b[127]}}, r_b};
  assign p = r_pipe[MUL_LAT-1];
  always_ff @(posedge clk) begin
    r_a <= a;
    r_b <= b;
    r_ss <= ss;
    r_su <= su;
    if (ce) begin
      r_pipe[0] <= w_ax * w_bx;
      for (int i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
endmodule

// File: rtl/mult_result_fifo.sv
// mult_result_fifo: first-word-fall-through FIFO, DEPTH x W
//   i_wr/i_wdata: push, i_rd: pop request (ignored while empty), o_valid/o_rdata: head
module mult_result_fifo #(
  parameter int W = 133,
  parameter int DEPTH = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic         o_valid,
  output logic [W-1:0] o_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_pop;
  assign o_valid = r_cnt != '0;
  assign o_rdata = r_mem[r_rp];
  assign w_pop = i_rd & o_valid;
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wp] <= i_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      assert (!(i_wr && !w_pop && r_cnt == CW'(DEPTH)));
      r_wp <= i_wr ? (r_wp == AW'(DEPTH - 1) ? '0 : r_wp + 1'b1) : r_wp;
      r_rp <= w_pop ? (r_rp == AW'(DEPTH - 1) ? '0 : r_rp + 1'b1) : r_rp;
      r_cnt <= r_cnt + CW'(i_wr) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/mult_issue_unit.sv
// mult_issue_unit: credit-controlled issue/retire stage around mult128x128
//   clk, rst (sync, active-high); bus: slave side of mult_issue_unit_if
module mult_issue_unit import mult_pkg::*; (
  input logic clk,
  input logic rst,
  mult_issue_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] r_credit;
  logic [127:0] r_a, r_b;
  logic r_ss, r_su;
  mtag_t r_issue;
  mtag_t r_line [MUL_LAT+1];
  mtag_t w_tail;
  logic [255:0] w_p;
  logic [128+TAGW-1:0] w_rdata;
  logic w_acc, w_pop;
  // credit = in-flight ops + FIFO entries, so the FIFO can never overflow
  assign bus.req_ready = !rst && r_credit < CW'(DEPTH);
  assign w_acc = bus.req_valid && bus.req_ready;
  assign w_pop = bus.res_valid && bus.res_ready;
  assign bus.busy = r_credit != '0;
  assign w_tail = r_line[MUL_LAT];
  assign {bus.res_tag, bus.res_data} = w_rdata;
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_a <= bus.req_a;
      r_b <= bus.req_b;
      r_ss <= bus.req_op == MULH;
      r_su <= bus.req_op == MULHSU;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue <= '0;
      for (int i = 0; i <= MUL_LAT; i++) r_line[i] <= '0;
      r_credit <= '0;
    end else begin
      r_issue <= '{vld: w_acc, op: bus.req_op, tag: bus.req_tag};
      r_line[0] <= r_issue;
      for (int i = 1; i <= MUL_LAT; i++) r_line[i] <= r_line[i-1];
      r_credit <= r_credit + CW'(w_acc) - CW'(w_pop);
    end
  end
  // the multiplier is never reset: products issued before rst retire with vld=0
  mult128x128 u_mul (
    .clk(clk),
    .ce(1'b1),
    .ss(r_ss),
    .su(r_su),
    .a(r_a),
    .b(r_b),
    .p(w_p)
  );
  mult_result_fifo #(.W(128 + TAGW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_wr(w_tail.vld),
    .i_wdata({w_tail.tag, sel_half(w_tail.op, w_p)}),
    .i_rd(bus.res_ready),
    .o_valid(bus.res_valid),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_mult_issue_unit.sv
// tb_mult_issue_unit: directed vector bench for mult_issue_unit
module tb_mult_issue_unit;
  import mult_pkg::*;
  typedef struct {
    logic [127:0] d;
    logic [4:0] t;
  } res_t;
  typedef struct {
    op_t op;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] e;
  } vec_t;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MIN = {1'b1, 127'b0};
  localparam logic [127:0] P64 = 128'h1 << 64;
  localparam int NV = 13;
  logic clk = 0;
  logic rst = 1;
  res_t exp_q[$];
  vec_t vt[NV];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops = 0;
  int first_pop = 0;
  int last_pop = 0;
  always #5 clk = ~clk;
  mult_issue_unit_if bus();
  mult_issue_unit dut(.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // one clock: check any pop at the falling edge, then move to just after the rising edge
  task automatic step();
    res_t e;
    @(negedge clk);
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stale_result: got tag %0d data %0h expected none", bus.res_tag, bus.res_data);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", bus.res_data, e.d);
        chk("res_tag", bus.res_tag, e.t);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic issue(input op_t op, input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] e, input logic [4:0] tag, input bit track,
                       output int waits);
    bus.req_valid = 1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_tag = tag;
    waits = 0;
    while (!bus.req_ready && waits < 200) begin
      step();
      waits++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got req_ready 0 expected 1");
    end else if (track) exp_q.push_back('{e, tag});
    step();
    bus.req_valid = 0;
  endtask
  task automatic drain(input string nm);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
    chk(nm, exp_q.size(), 0);
  endtask
  task automatic lat_check(input logic [127:0] a, input logic [127:0] b,
                           input logic [4:0] tag, input logic [127:0] e);
    int w;
    int k;
    bus.res_ready = 0;
    issue(MUL, a, b, e, tag, 1, w);
    k = 0;
    while (!bus.res_valid && k < 40) begin
      step();
      k++;
    end
    chk("latency", k, 20);
    chk("lat_data", bus.res_data, e);
    chk("lat_tag", bus.res_tag, tag);
    bus.res_ready = 1;
    step();
    bus.res_ready = 0;
    chk("lat_empty", bus.res_valid, 0);
    chk("lat_idle", bus.busy, 0);
  endtask
  initial begin
    int w;
    int acc;
    int wsum;
    int cnt;
    vt[0] = '{MUL, 128'd3, 128'd5, 128'd15};
    vt[1] = '{MULH, ONES, 128'd1, ONES};
    vt[2] = '{MULHU, ONES, 128'd1, 128'd0};
    vt[3] = '{MULHSU, ONES, ONES, ONES};
    vt[4] = '{MUL, P64, P64, 128'd0};
    vt[5] = '{MULHU, P64, P64, 128'd1};
    vt[6] = '{MULH, MIN, MIN, 128'h1 << 126};
    vt[7] = '{MULHSU, MIN, 128'd2, ONES};
    vt[8] = '{MULH, MIN, ONES, 128'd0};
    vt[9] = '{MUL, ONES, ONES, 128'd1};
    vt[10] = '{MULHU, ONES, ONES, ONES - 128'd1};
    vt[11] = '{MULH, 128'd7, ONES - 128'd2, ONES};
    vt[12] = '{MULHSU, 128'd1, ONES, 128'd0};
    bus.req_valid = 0;
    bus.req_op = MUL;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_tag = '0;
    bus.res_ready = 0;
    step();
    step();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 0;
    #1;
    chk("post_rst_ready", bus.req_ready, 1);
    lat_check(128'd3, 128'd5, 5'd7, 128'd15);
    bus.res_ready = 1;
    pops = 0;
    for (int i = 0; i < NV; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].e, 5'(i), 1, w);
      chk("vec_wait", w, 0);
    end
    drain("vec_drain");
    chk("vec_gap", last_pop - first_pop, NV - 1);
    bus.res_ready = 0;
    acc = 0;
    bus.req_valid = 1;
    for (int c = 0; c < 60; c++) begin
      bus.req_op = MUL;
      bus.req_a = 128'(acc);
      bus.req_b = 128'd3;
      bus.req_tag = 5'(acc);
      if (bus.req_ready) begin
        exp_q.push_back('{128'(acc * 3), 5'(acc)});
        acc++;
      end
      step();
    end
    bus.req_valid = 0;
    chk("fill_accepts", acc, DEPTH);
    chk("fill_ready", bus.req_ready, 0);
    chk("fill_busy", bus.busy, 1);
    chk("fill_head", bus.res_valid, 1);
    bus.res_ready = 1;
    for (int j = 0; j < 10; j++) begin
      issue(MUL, 128'(100 + j), 128'd7, 128'((100 + j) * 7), 5'(DEPTH + j), 1, w);
      chk("credit_wait", w, j == 0 ? 1 : 0);
    end
    drain("fill_drain");
    chk("fill_ready_again", bus.req_ready, 1);
    chk("fill_idle", bus.busy, 0);
    pops = 0;
    wsum = 0;
    for (int i = 0; i < 40; i++) begin
      issue(i[0] ? MULHU : MUL, 128'(i + 1), 128'(i + 2),
            i[0] ? 128'd0 : 128'((i + 1) * (i + 2)), 5'(i), 1, w);
      wsum += w;
    end
    chk("stream_waits", wsum, 0);
    drain("stream_drain");
    chk("stream_gap", last_pop - first_pop, 39);
    for (int i = 0; i < 10; i++) issue(MUL, 128'(i + 9), 128'd9, 128'd0, 5'(i), 0, w);
    step();
    step();
    step();
    rst = 1;
    step();
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.req_ready, 0);
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.res_valid) cnt++;
    end
    chk("midrst_no_stale", cnt, 0);
    lat_check(128'd2, 128'd2, 5'd3, 128'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
